// File: rtl/bus_grant_sched_pkg.sv
// Shared definitions for the bus_grant_sched round-robin bus scheduler.
package bus_grant_sched_pkg;

  // Scheduler FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Default configuration
  localparam int unsigned DEF_NREQ        = 3;
  localparam int unsigned DEF_HOLD_MAX    = 16;
  localparam int unsigned DEF_TURN_CYCLES = 1;

  // clog2 that never returns zero, so index/counter vectors stay at least 1 bit wide
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_grant_sched_rr_pick.sv
// Combinational round-robin picker: first eligible index after 'last', wrapping modulo NREQ.
module rr_pick
  import bus_grant_sched_pkg::*;
#(
  parameter int unsigned NREQ = DEF_NREQ,
  localparam int unsigned IW = clog2_w(NREQ)
) (
  input  logic [NREQ-1:0] eligible,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win_oh,
  output logic [IW-1:0]   win_idx,
  output logic            any_valid
);

  int unsigned   cand;
  logic [IW-1:0] cidx;

  // Scan last+1, last+2, ... so 'last' itself is checked last (lowest priority)
  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    any_valid = 1'b0;
    cand      = 0;
    cidx      = '0;
    for (int unsigned off = 1; off <= NREQ; off++) begin
      cand = (32'(last) + off) % NREQ;
      cidx = cand[IW-1:0];
      if (!any_valid && eligible[cidx]) begin
        any_valid    = 1'b1;
        win_idx      = cidx;
        win_oh[cidx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_grant_sched.sv
// Round-robin bus scheduler with held grants and a fixed turnaround gap.
// Optional hold watchdog enabled by defining BUS_GRANT_SCHED_WATCHDOG_EN.
module bus_grant_sched
  import bus_grant_sched_pkg::*;
#(
  parameter int unsigned NREQ        = DEF_NREQ,
  parameter int unsigned HOLD_MAX    = DEF_HOLD_MAX,
  parameter int unsigned TURN_CYCLES = DEF_TURN_CYCLES,
  localparam int unsigned IW = clog2_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam int unsigned HW = clog2_w(HOLD_MAX + 1);
  localparam int unsigned TW = clog2_w(TURN_CYCLES + 1);

  state_e          state;
  logic [IW-1:0]   last;
  logic [HW-1:0]   hold_cnt;
  logic [TW-1:0]   turn_cnt;
  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            wd_fire;

  assign eligible = req & ~mask;
  assign busy     = (state != ST_IDLE);

  rr_pick #(
    .NREQ(NREQ)
  ) u_rr_pick (
    .eligible  (eligible),
    .last      (last),
    .win_oh    (pick_oh),
    .win_idx   (pick_idx),
    .any_valid (pick_any)
  );

`ifdef BUS_GRANT_SCHED_WATCHDOG_EN
  // Force release on the edge that would start the (HOLD_MAX+1)-th grant cycle
  always_comb begin
    wd_fire = (state == ST_GRANT) && req[gnt_id] && (hold_cnt == HW'(HOLD_MAX - 1));
  end

  // Mask clears whenever the requester lets go; set only by a forced release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mask <= '0;
    end else begin
      mask <= (mask & req) | (wd_fire ? (NREQ'(1) << gnt_id) : '0);
    end
  end
`else
  assign wd_fire = 1'b0;
  assign mask    = '0;
`endif

  // Scheduler FSM with registered grant outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      last     <= IW'(NREQ - 1);
      hold_cnt <= '0;
      turn_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            gnt      <= pick_oh;
            gnt_id   <= pick_idx;
            last     <= pick_idx;
            hold_cnt <= '0;
            state    <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Other requesters are ignored here: no preemption
          if (!req[gnt_id] || wd_fire) begin
            gnt      <= '0;
            gnt_id   <= '0;
            turn_cnt <= '0;
            timeout  <= wd_fire;
            state    <= ST_TURN;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_TURN: begin
          if (turn_cnt == TW'(TURN_CYCLES - 1)) begin
            state <= ST_IDLE;
          end else begin
            turn_cnt <= turn_cnt + TW'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_sched.sv
// Self-checking bench for bus_grant_sched: directed steps plus randomized traffic
// against a transaction-level reference model (owner / hold length / gap countdown).
module tb_bus_grant_sched;

  localparam int unsigned NREQ        = 3;
  localparam int unsigned HOLD_MAX    = 16;
  localparam int unsigned TURN_CYCLES = 1;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [1:0]      gnt_id;
  logic            busy;
  logic            timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int              m_owner;
  int              m_last;
  int              m_held;
  int              m_blocked;
  bit [NREQ-1:0]   m_masked;
  bit              m_to;

  bus_grant_sched #(
    .NREQ        (NREQ),
    .HOLD_MAX    (HOLD_MAX),
    .TURN_CYCLES (TURN_CYCLES)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_last    = NREQ - 1;
    m_held    = 0;
    m_blocked = 0;
    m_masked  = '0;
    m_to      = 1'b0;
  endtask

  // One clock edge of the behavioural rules, using req as sampled at that edge
  task automatic model_edge();
    m_to = 1'b0;
    for (int i = 0; i < NREQ; i++) if (!req[i]) m_masked[i] = 1'b0;
    if (m_owner >= 0) begin
      if (!req[m_owner]) begin
        m_owner   = -1;
        m_blocked = TURN_CYCLES;
`ifdef BUS_GRANT_SCHED_WATCHDOG_EN
      end else if (m_held == HOLD_MAX) begin
        m_masked[m_owner] = 1'b1;
        m_to      = 1'b1;
        m_owner   = -1;
        m_blocked = TURN_CYCLES;
`endif
      end else begin
        m_held++;
      end
    end else if (m_blocked > 0) begin
      m_blocked--;
    end else begin
      for (int off = 1; off <= NREQ; off++) begin
        int c;
        c = (m_last + off) % NREQ;
        if (m_owner < 0 && req[c] && !m_masked[c]) begin
          m_owner = c;
          m_last  = c;
          m_held  = 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [NREQ-1:0] mg;
    mg = '0;
    if (m_owner >= 0) mg[m_owner] = 1'b1;
    chk("gnt", 32'(gnt), 32'(mg));
    chk("gnt_id", 32'(gnt_id), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("busy", 32'(busy), 32'((m_owner >= 0) || (m_blocked > 0)));
    chk("timeout", 32'(timeout), 32'(m_to));
  endtask

  // Drive req, take one edge, then compare 1 time unit later
  task automatic cycle(input logic [NREQ-1:0] r);
    req = r;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int            cnt;
    int            cnt_to;
    int            rot_prev;
    int            rot_seen;
    int            lowleft [NREQ];
    logic [NREQ-1:0] r;

    // Reset held with all requests active
    rst = 1'b0;
    req = 3'b111;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_all();
    end
    chk("reset_gnt", 32'(gnt), 32'd0);
    rst = 1'b1;
    cycle(3'b111);
    chk("first_gnt", 32'(gnt), 32'b001);
    cycle(3'b000);
    cycle(3'b000);

    // Single request held four cycles
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(3'b001);
      if (gnt == 3'b001) cnt++;
    end
    cycle(3'b000);
    chk("single_drop_gnt", 32'(gnt), 32'd0);
    cycle(3'b000);
    chk("single_len", 32'(cnt), 32'd4);
    chk("single_busy_after", 32'(busy), 32'd0);

    // Rotation: each owner releases after 3 grant cycles, reasserts 2 cycles later
    rot_prev = 0;
    rot_seen = 0;
    for (int i = 0; i < NREQ; i++) lowleft[i] = 0;
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (m_owner == i && m_held == 3) lowleft[i] = 2;
        r[i] = (lowleft[i] == 0);
        if (lowleft[i] > 0) lowleft[i]--;
      end
      cycle(r);
      if (m_owner >= 0 && m_held == 1) begin
        chk("rot_order", 32'(gnt_id), 32'((rot_prev + 1) % NREQ));
        rot_prev = (rot_prev + 1) % NREQ;
        rot_seen++;
      end
    end
    chk("rot_count_ge4", 32'(rot_seen >= 4), 32'd1);
    for (int i = 0; i < 4; i++) cycle(3'b000);

    // Wrap-around priority
    cycle(3'b100);
    cycle(3'b000);
    cycle(3'b000);
    cycle(3'b101);
    chk("wrap_from_2", 32'(gnt), 32'b001);
    cycle(3'b000);
    cycle(3'b000);
    cycle(3'b101);
    chk("wrap_from_0", 32'(gnt), 32'b100);
    for (int i = 0; i < 3; i++) cycle(3'b000);

    // No preemption
    cycle(3'b010);
    for (int i = 0; i < 3; i++) begin
      cycle(3'b011);
      chk("no_preempt", 32'(gnt), 32'b010);
    end
    cycle(3'b001);
    chk("preempt_release", 32'(gnt), 32'd0);
    cycle(3'b001);
    cycle(3'b001);
    chk("after_turn_gnt0", 32'(gnt), 32'b001);
    for (int i = 0; i < 3; i++) cycle(3'b000);

    // Long hold on requester 2
    cnt    = 0;
    cnt_to = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(3'b100);
      if (gnt == 3'b100) cnt++;
      if (timeout) cnt_to++;
    end
`ifdef BUS_GRANT_SCHED_WATCHDOG_EN
    chk("wd_grant_len", 32'(cnt), 32'(HOLD_MAX));
    chk("wd_timeouts", 32'(cnt_to), 32'd1);
`else
    chk("hold_grant_len", 32'(cnt), 32'd40);
    chk("hold_timeouts", 32'(cnt_to), 32'd0);
`endif
    cycle(3'b000);
    cycle(3'b100);
    cycle(3'b100);
    for (int i = 0; i < 3; i++) cycle(3'b000);

    // Asynchronous reset in the middle of a grant
    cycle(3'b010);
    cycle(3'b010);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_gnt", 32'(gnt), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic against the model
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[i]) r[i] = ($urandom_range(0, 5) != 0);
        else      r[i] = ($urandom_range(0, 3) == 0);
      end
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
